mc_control_hs: RTL
==================

# mc_control_hs

Multi-cycle RV32I control unit with memory handshakes. It replaces the fixed-latency controller in the Multi-Cycle core. Fetch and data accesses wait on ready strobes with a programmable timeout. The unit adds LUI/AUIPC, folds ALU-control decode in, traps on illegal encodings, and counts retired instructions.

## Interface
- CNT_W, 32: width of retired-instruction counter.
- EN_UPPER, 1: 1 = LUI (0110111) and AUIPC (0010111) legal; 0 = both trap as illegal opcode.
- TIMEOUT, 15: maximum wait cycles on IM_READY/DM_READY before trap; 0 = wait forever. Counter width is $clog2(TIMEOUT+1), minimum 1.

- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- OPCODE  in  7  IR[6:0].
- FUNCT3  in  3  IR[14:12].
- FUNCT7  in  7  IR[31:25].
- IM_READY  in  1  instruction memory data valid this cycle.
- DM_READY  in  1  data memory access complete this cycle.
- PCWrite  out  1  PC <= ALUOut register.
- Branch  out  1  PC <= ALUOut register if datapath compare result is 1.
- IMRead, IRWrite, RegWrite, MemRead, MemWrite, MemToReg, ALUOutWrite, SaveSig, NullLSB  out  1 each  datapath strobes.
- ALUSrcA  out  2  00 PC, 01 rs1, 10 zero.
- ALUSrcB  out  3  000 rs2, 001 const 4, 010 S-imm, 011 B-imm, 100 I-imm, 101 J-imm, 110 U-imm.
- ALUCtl  out  4  0000 ADD, 0001 SUB, 0010 SLT, 0011 SGE, 0100 SLTU, 0101 SGEU, 0110 XOR, 0111 AND, 1000 OR, 1001 SLL, 1010 SRL, 1011 SRA, 1100 EQ, 1101 NE.
- Trap  out  1  sticky trap flag.
- TrapCause  out  2  00 none, 01 illegal opcode, 10 memory timeout, 11 illegal funct.
- Retired  out  CNT_W  completed-instruction count.

## Operation
- Every output not listed for a state is 0. ALUCtl is ADD unless stated.
- FETCH: IMRead=1, ALUSrcA=00, ALUSrcB=001, ALUOutWrite=1. IRWrite=IM_READY (Mealy). The unit stays in FETCH while IM_READY=0, then goes to DECODE.
- DECODE: illegal opcode -> TRAP(01). JAL/JALR: RegWrite=1, SaveSig=1, so rd <= PC+4. JAL -> JTGT; JALR -> JRTGT.
- DECODE, all other legal opcodes: PCWrite=1, ALUSrcA=00, ALUOutWrite=1. ALUSrcB=110 for AUIPC, otherwise 011. Next state by opcode: branch -> BR, load -> LDA, store -> STA, OP-IMM -> OPI, OP -> OPR, LUI -> LUI_X, AUIPC -> WB.
- JTGT: ALUSrcA=00, ALUSrcB=101, ALUOutWrite=1, then JPC.
- JRTGT: ALUSrcA=01, ALUSrcB=100, NullLSB=1, ALUOutWrite=1, then JPC.
- JPC: PCWrite=1, then FETCH.
- BR: ALUSrcA=01, ALUSrcB=000, Branch=1. ALUCtl from FUNCT3: 000 EQ, 001 NE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU. Then FETCH. FUNCT3 010/011 -> TRAP(11) with Branch=0.
- LDA: ALUSrcA=01, ALUSrcB=100, ALUOutWrite=1, then LDM.
- LDM: MemRead=1 held while DM_READY=0, then LDW.
- LDW: RegWrite=1, MemToReg=1, SaveSig=1, then FETCH.
- STA: ALUSrcB=010, otherwise as LDA, then STM.
- STM: MemWrite=1 held while DM_READY=0, then FETCH.
- OPI: ALUSrcA=01, ALUSrcB=100, ALUOutWrite=1. OPR: same with ALUSrcB=000. Both go to WB.
- OPI/OPR ALUCtl: FUNCT3 000 ADD (OPR with FUNCT7=0100000 gives SUB), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (FUNCT7 0000000/0100000), 110 OR, 111 AND.
- OPI/OPR illegal funct -> TRAP(11). Illegal funct means FUNCT7 is not 0000000/0100000 where FUNCT7 is checked, or SUB/SRA bit pattern is used with any other FUNCT3.
- LUI_X: ALUSrcA=10, ALUSrcB=110, ALUOutWrite=1, then WB.
- WB: RegWrite=1, SaveSig=1, then FETCH.
- TRAP: Trap=1 and TrapCause held. Absorbing until RST, with no strobes.
- Retired increments by 1 on every transition into FETCH from BR, JPC, LDW, STM or WB. It wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous): state=FETCH, wait counter=0, Retired=0, Trap=0, TrapCause=00. Outputs immediately take FETCH values: IMRead=1, ALUSrcB=001, ALUOutWrite=1.
- Minimum latencies with ready=1 on the first cycle:
  - branch 3 cycles; OP/OP-IMM/LUI 4; AUIPC 3.
  - JAL/JALR 4; load 5; store 4.
- Wait counter: cleared on entry to FETCH, LDM or STM. Increments each cycle that ready=0 in those states.
- Timeout: if ready=0 while counter==TIMEOUT-1, the next state is TRAP(10). With TIMEOUT=N, N wait cycles are tolerated and ready arriving on cycle N+1 still fails.
- Ready and timeout in the same cycle: ready wins.
- MemRead/MemWrite remain asserted every cycle of LDM/STM, including the completing cycle. They drop the cycle after DM_READY=1.
- RST mid-instruction aborts the instruction. No PC, register or memory strobe is asserted after RST rises.

## Test plan
- ADDI x1,x0,5 with IM_READY=1 -> states FETCH,DECODE,OPI,WB; ALUCtl=0000, ALUSrcB=100; RegWrite=1 only in WB; Retired 0->1.
- LW with DM_READY held low 3 cycles, TIMEOUT=15 -> MemRead=1 for 4 cycles; LDW asserts RegWrite=1, MemToReg=1; total 8 cycles.
- Store with DM_READY never asserted, TIMEOUT=4 -> MemWrite high 4 cycles then TRAP; Trap=1, TrapCause=10; outputs stay 0 for 20 further cycles.
- OPCODE=0110111 with EN_UPPER=1 -> LUI_X with ALUSrcA=10, ALUSrcB=110. With EN_UPPER=0 -> TRAP with TrapCause=01.
- BNE (FUNCT3=001) -> BR with ALUCtl=1101, Branch=1. FUNCT3=010 -> TrapCause=11 and Branch never asserted.
- JALR -> DECODE RegWrite=1; JRTGT NullLSB=1, ALUSrcB=100; JPC PCWrite=1. CNT_W=2 after 4 retires -> Retired wraps to 0. Async RST in LDM -> MemRead=0 immediately, Retired=0.

Source files
------------

// File: rtl/mc_control_hs.sv
// Multi-cycle RV32I control unit: ready-handshaked fetch and data access with timeout,
// folded ALU-control decode, illegal-encoding traps and a retired-instruction counter.
module mc_control_hs #(
    parameter int unsigned CNT_W    = 32,
    parameter bit          EN_UPPER = 1'b1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNCT3,
    input  logic [6:0]       FUNCT7,
    input  logic             IM_READY,
    input  logic             DM_READY,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IMRead,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             ALUOutWrite,
    output logic             SaveSig,
    output logic             NullLSB,
    output logic [1:0]       ALUSrcA,
    output logic [2:0]       ALUSrcB,
    output logic [3:0]       ALUCtl,
    output logic             Trap,
    output logic [1:0]       TrapCause,
    output logic [CNT_W-1:0] Retired
);
    localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_JTGT   = 4'd2;
    localparam logic [3:0] S_JRTGT  = 4'd3;
    localparam logic [3:0] S_JPC    = 4'd4;
    localparam logic [3:0] S_BR     = 4'd5;
    localparam logic [3:0] S_LDA    = 4'd6;
    localparam logic [3:0] S_LDM    = 4'd7;
    localparam logic [3:0] S_LDW    = 4'd8;
    localparam logic [3:0] S_STA    = 4'd9;
    localparam logic [3:0] S_STM    = 4'd10;
    localparam logic [3:0] S_OPI    = 4'd11;
    localparam logic [3:0] S_OPR    = 4'd12;
    localparam logic [3:0] S_LUI_X  = 4'd13;
    localparam logic [3:0] S_WB     = 4'd14;
    localparam logic [3:0] S_TRAP   = 4'd15;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SGE  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SGEU = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_EQ   = 4'b1100;
    localparam logic [3:0] ALU_NE   = 4'b1101;

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic [1:0]        cause;
    logic [1:0]        next_cause;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_ready;
    logic              timeout_hit;
    logic              f7_zero;
    logic              f7_alt;
    logic              in_opr;
    logic [3:0]        op_ctl;
    logic              op_bad;
    logic [3:0]        br_ctl;
    logic              br_bad;

    assign f7_zero     = (FUNCT7 == 7'b0000000);
    assign f7_alt      = (FUNCT7 == 7'b0100000);
    assign in_opr      = (state == S_OPR);
    assign wait_ready  = (state == S_FETCH) ? IM_READY : DM_READY;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign Trap        = (state == S_TRAP);
    assign TrapCause   = cause;

    // OP-IMM leaves FUNCT7 unchecked except on shifts, where it selects SRL/SRA
    always_comb begin
        op_ctl = ALU_ADD;
        op_bad = 1'b0;
        case (FUNCT3)
            3'b000: begin
                if (in_opr && f7_alt) op_ctl = ALU_SUB;
                op_bad = in_opr && !f7_zero && !f7_alt;
            end
            3'b001: begin op_ctl = ALU_SLL;  op_bad = !f7_zero; end
            3'b010: begin op_ctl = ALU_SLT;  op_bad = in_opr && !f7_zero; end
            3'b011: begin op_ctl = ALU_SLTU; op_bad = in_opr && !f7_zero; end
            3'b100: begin op_ctl = ALU_XOR;  op_bad = in_opr && !f7_zero; end
            3'b101: begin
                op_ctl = f7_alt ? ALU_SRA : ALU_SRL;
                op_bad = !f7_zero && !f7_alt;
            end
            3'b110: begin op_ctl = ALU_OR;   op_bad = in_opr && !f7_zero; end
            default: begin op_ctl = ALU_AND; op_bad = in_opr && !f7_zero; end
        endcase
    end

    always_comb begin
        br_ctl = ALU_EQ;
        br_bad = 1'b0;
        case (FUNCT3)
            3'b000:  br_ctl = ALU_EQ;
            3'b001:  br_ctl = ALU_NE;
            3'b100:  br_ctl = ALU_SLT;
            3'b101:  br_ctl = ALU_SGE;
            3'b110:  br_ctl = ALU_SLTU;
            3'b111:  br_ctl = ALU_SGEU;
            default: br_bad = 1'b1;
        endcase
    end

    always_comb begin
        next_state  = state;
        next_cause  = 2'b00;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        IMRead      = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        ALUOutWrite = 1'b0;
        SaveSig     = 1'b0;
        NullLSB     = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 3'b000;
        ALUCtl      = ALU_ADD;
        case (state)
            S_FETCH: begin
                IMRead      = 1'b1;
                IRWrite     = IM_READY;
                ALUSrcB     = 3'b001;
                ALUOutWrite = 1'b1;
                if (IM_READY) next_state = S_DECODE;
                else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = 2'b10;
                end
            end
            S_DECODE: begin
                if (OPCODE == OP_JAL || OPCODE == OP_JALR) begin
                    RegWrite   = 1'b1;
                    SaveSig    = 1'b1;
                    next_state = (OPCODE == OP_JAL) ? S_JTGT : S_JRTGT;
                end else begin
                    PCWrite     = 1'b1;
                    ALUOutWrite = 1'b1;
                    ALUSrcB     = (OPCODE == OP_AUIPC) ? 3'b110 : 3'b011;
                    case (OPCODE)
                        OP_BRANCH: next_state = S_BR;
                        OP_LOAD:   next_state = S_LDA;
                        OP_STORE:  next_state = S_STA;
                        OP_IMM:    next_state = S_OPI;
                        OP_REG:    next_state = S_OPR;
                        OP_LUI:    next_state = EN_UPPER ? S_LUI_X : S_TRAP;
                        OP_AUIPC:  next_state = EN_UPPER ? S_WB : S_TRAP;
                        default:   next_state = S_TRAP;
                    endcase
                    if (next_state == S_TRAP) begin
                        PCWrite     = 1'b0;
                        ALUOutWrite = 1'b0;
                        ALUSrcB     = 3'b000;
                        next_cause  = 2'b01;
                    end
                end
            end
            S_JTGT: begin
                ALUSrcB     = 3'b101;
                ALUOutWrite = 1'b1;
                next_state  = S_JPC;
            end
            S_JRTGT: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 3'b100;
                NullLSB     = 1'b1;
                ALUOutWrite = 1'b1;
                next_state  = S_JPC;
            end
            S_JPC: begin
                PCWrite    = 1'b1;
                next_state = S_FETCH;
            end
            S_BR: begin
                if (br_bad) begin
                    next_state = S_TRAP;
                    next_cause = 2'b11;
                end else begin
                    ALUSrcA    = 2'b01;
                    Branch     = 1'b1;
                    ALUCtl     = br_ctl;
                    next_state = S_FETCH;
                end
            end
            S_LDA, S_STA: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = (state == S_LDA) ? 3'b100 : 3'b010;
                ALUOutWrite = 1'b1;
                next_state  = (state == S_LDA) ? S_LDM : S_STM;
            end
            S_LDM, S_STM: begin
                MemRead  = (state == S_LDM);
                MemWrite = (state == S_STM);
                if (DM_READY) next_state = (state == S_LDM) ? S_LDW : S_FETCH;
                else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = 2'b10;
                end
            end
            S_LDW: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                SaveSig    = 1'b1;
                next_state = S_FETCH;
            end
            S_OPI, S_OPR: begin
                if (op_bad) begin
                    next_state = S_TRAP;
                    next_cause = 2'b11;
                end else begin
                    ALUSrcA     = 2'b01;
                    ALUSrcB     = (state == S_OPI) ? 3'b100 : 3'b000;
                    ALUOutWrite = 1'b1;
                    ALUCtl      = op_ctl;
                    next_state  = S_WB;
                end
            end
            S_LUI_X: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 3'b110;
                ALUOutWrite = 1'b1;
                next_state  = S_WB;
            end
            S_WB: begin
                RegWrite   = 1'b1;
                SaveSig    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_TRAP;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_FETCH;
            cause    <= 2'b00;
            wait_cnt <= '0;
            Retired  <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP && state != S_TRAP) cause <= next_cause;
            if (next_state != state &&
                (next_state == S_FETCH || next_state == S_LDM || next_state == S_STM))
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_LDM || state == S_STM) && !wait_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            // only BR, JPC, LDW, STM and WB ever return to FETCH
            if (state != S_FETCH && next_state == S_FETCH)
                Retired <= Retired + CNT_W'(1);
        end
    end
endmodule
